reel_stop_sequencer: RTL and testbench



---
 rtl/reel_stop_sequencer.sv | 159 +++++++++++++++
 tb/tb_reel_stop_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reel_stop_sequencer.sv
// Slot-machine play sequencer: spins four hex reels on the LFSR word, then locks them
// left to right with a fixed stagger, applying the rigged-win/lose/random outcome policy.
module reel_stop_sequencer #(
    parameter int SPIN_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic        oclk,
    input  logic        RST,
    input  logic        EIN,
    input  logic        submit,
    input  logic        rig_win,
    input  logic        rig_lose,
    input  logic [15:0] rand_in,
    output logic        rng_en,
    output logic [15:0] reel_val,
    output logic [3:0]  reel_lock,
    output logic        busy,
    output logic        done,
    output logic        win
);

    typedef enum logic [1:0] {IDLE, SPIN, STOP, DONE} state_t;
    typedef enum logic [1:0] {MODE_RANDOM, MODE_WIN, MODE_LOSE} mode_t;

    localparam logic [CNT_W-1:0] SPIN_LAST    = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    state_t            state_reg, state_next;
    mode_t             mode_reg, mode_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [15:0]       reel_val_reg, reel_val_next;
    logic [3:0]        reel_lock_reg, reel_lock_next;
    logic [3:0]        lock_now;
    logic              win_reg, win_next;
    logic              submit_q_reg;
    logic              rng_en_reg;
    logic              start;
    logic              load_all;
    logic              load_active;
    logic              clear;
    logic [3:0]        v3;

    assign start = submit & ~submit_q_reg;
    assign v3    = reel_val_reg[15:12];

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        cnt_next       = cnt_reg;
        reel_lock_next = reel_lock_reg;
        win_next       = win_reg;
        lock_now       = 4'b0000;
        load_all       = 1'b0;
        load_active    = 1'b0;
        clear          = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = SPIN;
                    cnt_next       = '0;
                    reel_lock_next = 4'b0000;
                    win_next       = 1'b0;
                    load_all       = 1'b1;
                    if (rig_win & ~rig_lose)
                        mode_next = MODE_WIN;
                    else if (rig_lose & ~rig_win)
                        mode_next = MODE_LOSE;
                    else
                        mode_next = MODE_RANDOM;
                end
            end
            SPIN: begin
                load_active = 1'b1;
                if (cnt_reg == SPIN_LAST) begin
                    lock_now   = 4'b1000;
                    cnt_next   = '0;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (reel_lock_reg[0]) begin
                    state_next = DONE;
                    win_next   = (reel_val_reg[15:12] == reel_val_reg[11:8]) &&
                                 (reel_val_reg[11:8]  == reel_val_reg[7:4])  &&
                                 (reel_val_reg[7:4]   == reel_val_reg[3:0]);
                end else begin
                    load_active = 1'b1;
                    if (cnt_reg == STAGGER_LAST) begin
                        // The next reel to lock is the one just right of the last locked reel
                        lock_now = {1'b0, reel_lock_reg[3:1] & ~reel_lock_reg[2:0]};
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                cnt_next       = '0;
                reel_lock_next = 4'b0000;
                win_next       = 1'b0;
                clear          = 1'b1;
            end
        endcase
        reel_lock_next = reel_lock_next | lock_now;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_reel
        logic [3:0] rnd_nib;
        logic [3:0] lock_val;
        assign rnd_nib = rand_in[4*gi +: 4];
        if (gi == 3) begin : g_left
            assign lock_val = rnd_nib;
        end else if (gi == 0) begin : g_right
            assign lock_val = (mode_reg == MODE_WIN)  ? v3  :
                              (mode_reg == MODE_LOSE) ? ~v3 : rnd_nib;
        end else begin : g_mid
            assign lock_val = (mode_reg == MODE_RANDOM) ? rnd_nib : v3;
        end
        assign reel_val_next[4*gi +: 4] =
            clear                                   ? 4'h0 :
            load_all                                ? rnd_nib :
            (!load_active || reel_lock_reg[gi])     ? reel_val_reg[4*gi +: 4] :
            lock_now[gi]                            ? lock_val : rnd_nib;
    end

    always_ff @(posedge oclk) begin
        if (RST || !EIN) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_RANDOM;
            cnt_reg       <= '0;
            reel_val_reg  <= 16'h0000;
            reel_lock_reg <= 4'b0000;
            win_reg       <= 1'b0;
            submit_q_reg  <= 1'b0;
            rng_en_reg    <= RST;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            cnt_reg       <= cnt_next;
            reel_val_reg  <= reel_val_next;
            reel_lock_reg <= reel_lock_next;
            win_reg       <= win_next;
            submit_q_reg  <= submit;
            rng_en_reg    <= (state_next != DONE);
        end
    end

    assign rng_en    = rng_en_reg;
    assign reel_val  = reel_val_reg;
    assign reel_lock = reel_lock_reg;
    assign busy      = (state_reg == SPIN) || (state_reg == STOP);
    assign done      = (state_reg == DONE);
    assign win       = win_reg;

endmodule

// File: tb/tb_reel_stop_sequencer.sv
// Randomized bench for reel_stop_sequencer: each play is checked edge by edge against a
// model that derives reel values from lock edges and the recorded rand_in history.
module tb_reel_stop_sequencer;

    localparam int SP     = 16;
    localparam int ST     = 4;
    localparam int DONE_E = SP + 3*ST + 1;

    logic        oclk = 1'b0;
    logic        RST, EIN, submit, rig_win, rig_lose;
    logic [15:0] rand_in;
    logic        rng_en, busy, done, win;
    logic [15:0] reel_val;
    logic [3:0]  reel_lock;

    reel_stop_sequencer #(.SPIN_CYCLES(SP), .STAGGER_CYCLES(ST), .CNT_W(8)) dut (
        .oclk(oclk), .RST(RST), .EIN(EIN), .submit(submit),
        .rig_win(rig_win), .rig_lose(rig_lose), .rand_in(rand_in),
        .rng_en(rng_en), .reel_val(reel_val), .reel_lock(reel_lock),
        .busy(busy), .done(done), .win(win)
    );

    always #5 oclk = ~oclk;

    int checks = 0;
    int errors = 0;
    int play_no = 0;
    logic [15:0] rnd [0:DONE_E];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge oclk);
        @(negedge oclk);
    endtask

    // Reel k locks SP + (3-k)*ST edges after the accept edge
    function automatic logic [3:0] model_nib(input int k, input int e, input bit wm, input bit lm);
        int L;
        logic [15:0] w;
        logic [3:0] v3;
        L = SP + (3 - k) * ST;
        if (e < L) begin
            w = rnd[e];
            return w[4*k +: 4];
        end
        w  = rnd[SP];
        v3 = w[15:12];
        if (k == 3) return v3;
        if (wm) return v3;
        if (lm) return (k == 0) ? ~v3 : v3;
        w = rnd[L];
        return w[4*k +: 4];
    endfunction

    task automatic check_idle(input string tag, input logic exp_rng);
        chk({tag, "_val"},  32'(reel_val), 32'h0);
        chk({tag, "_lock"}, 32'(reel_lock), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_win"},  32'(win), 32'h0);
        chk({tag, "_rng"},  32'(rng_en), 32'(exp_rng));
    endtask

    task automatic play(input bit rw, input bit rl, input bit eq, input bit hold,
                        input bit repulse, input int abort_e, input int f3);
        bit wm, lm;
        logic [3:0]  cn;
        logic [15:0] exp_val;
        logic [3:0]  exp_lock;
        logic        exp_win;
        wm = rw & ~rl;
        lm = rl & ~rw;
        cn = 4'($urandom);
        play_no++;
        for (int e = 0; e <= DONE_E; e++) begin
            rnd[e] = 16'($urandom);
            if (eq && (e == SP || e == SP+ST || e == SP+2*ST || e == SP+3*ST))
                rnd[e] = {cn, cn, cn, cn};
            if (e == SP && f3 >= 0)
                rnd[e][15:12] = f3[3:0];
            rand_in = rnd[e];
            if (e == 0) begin
                submit   = 1'b1;
                rig_win  = rw;
                rig_lose = rl;
            end else begin
                submit   = hold ? 1'b1 : (repulse && e == 4);
                rig_win  = 1'($urandom);
                rig_lose = 1'($urandom);
            end
            if (e == abort_e) RST = 1'b1;
            cyc();
            if (e == abort_e) begin
                RST = 1'b0;
                check_idle("abort", 1'b1);
                $display("play %0d aborted at E%0d", play_no, e);
                return;
            end
            exp_lock = {e >= SP, e >= SP+ST, e >= SP+2*ST, e >= SP+3*ST};
            exp_val  = {model_nib(3, e, wm, lm), model_nib(2, e, wm, lm),
                        model_nib(1, e, wm, lm), model_nib(0, e, wm, lm)};
            exp_win  = (e == DONE_E) && (exp_val[15:12] == exp_val[11:8]) &&
                       (exp_val[11:8] == exp_val[7:4]) && (exp_val[7:4] == exp_val[3:0]);
            chk("lock", 32'(reel_lock), 32'(exp_lock));
            chk("val",  32'(reel_val),  32'(exp_val));
            chk("busy", 32'(busy),      32'(e < DONE_E));
            chk("done", 32'(done),      32'(e == DONE_E));
            chk("rng",  32'(rng_en),    32'(e < DONE_E));
            chk("win",  32'(win),       32'(exp_win));
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                cyc();
                chk("hold_done", 32'(done), 32'h1);
                chk("hold_busy", 32'(busy), 32'h0);
            end
        end
        submit = 1'b0;
        cyc();
        chk("post_done", 32'(done), 32'h1);
        $display("play %0d rw=%0d rl=%0d reel_val=%h win=%0d", play_no, rw, rl, reel_val, win);
    endtask

    initial begin
        RST = 1'b1; EIN = 1'b1; submit = 1'b0; rig_win = 1'b0; rig_lose = 1'b0; rand_in = 16'h0;
        @(negedge oclk);
        repeat (3) cyc();
        check_idle("reset", 1'b1);
        RST = 1'b0;
        cyc();

        play(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 10);   // rigged win, V3=A
        play(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 3);    // rigged lose, V3=3
        for (int i = 0; i < 6; i++) begin
            bit a, b;
            a = (i < 3) ? 1'b1 : 1'($urandom);
            b = (i < 3) ? 1'b1 : 1'($urandom);
            play(a, b, 1'(i % 2), 1'b0, 1'b0, -1, -1);
        end
        play(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);   // submit held 40 cycles
        play(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);   // re-pulse during SPIN
        play(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22, -1);   // reset abort after two locks
        play(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);

        EIN = 1'b0;
        cyc();
        check_idle("ein_off", 1'b0);
        EIN = 1'b1;
        cyc();
        chk("ein_on_rng", 32'(rng_en), 32'h1);
        chk("ein_on_busy", 32'(busy), 32'h0);
        play(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
